// File: rtl/switch_debounce_if.sv
// Switch debouncer signal bundle: the raw pin level going in, the clean level
// and its press/release pulses coming out.
interface switch_debounce_if;
  logic i_Switch;
  logic o_Switch_state;
  logic o_Rise;
  logic o_Fall;

  // Master drives the raw pin and consumes the debounced results.
  modport master (
    output i_Switch,
    input  o_Switch_state,
    input  o_Rise,
    input  o_Fall
  );

  // Slave is the debouncer itself.
  modport slave (
    input  i_Switch,
    output o_Switch_state,
    output o_Rise,
    output o_Fall
  );
endinterface

// File: rtl/switch_debounce.sv
// Single-channel switch debouncer. The raw level passes through a two-flop
// synchronizer. A new level is accepted only after sync2 has differed from
// the published level for DEBOUNCE_LIMIT consecutive cycles. Any cycle in
// which sync2 agrees with the published level throws the progress away.
// Registered one-cycle press/release pulses accompany each accepted change.
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CNT_W          = $clog2(DEBOUNCE_LIMIT)
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  switch_debounce_if.slave  sw
);

  // Terminal count: reaching it while still differing accepts the new level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             switch_state;
  logic             rise;
  logic             fall;

  // Two-stage synchronizer; only sync2 is ever used by the filter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse sync1 and
  // sync2 into a single stage.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw.i_Switch;
      sync2 <= sync1;
    end
  end

  // Stability counter next value and acceptance decision.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    accept   = 1'b0;
    cnt_next = '0;
    if (sync2 != switch_state) begin
      if (cnt == CNT_MAX) begin
        accept = 1'b1;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  // Counter, published level and the edge pulses that mark its changes.
  // NOTE: the asynchronous reset clears all filter state, so a count that is
  // in progress when reset arrives is abandoned rather than resumed.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt          <= '0;
      switch_state <= 1'b0;
      rise         <= 1'b0;
      fall         <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      rise <= accept &  sync2;
      fall <= accept & ~sync2;
      if (accept) begin
        switch_state <= sync2;
      end
    end
  end

  assign sw.o_Switch_state = switch_state;
  assign sw.o_Rise         = rise;
  assign sw.o_Fall         = fall;

endmodule

// File: tb/tb_switch_debounce.sv
// Randomised scoreboard bench for switch_debounce with DEBOUNCE_LIMIT = 8.
// A behavioural model keeps the history of sampled pin levels. It accepts a
// new level once the last LIMIT values seen two edges late all disagree with
// the published level. Expected results are queued per clock and a separate
// monitor pops and compares them on the falling edge.
module tb_switch_debounce;

  localparam int LIMIT = 8;

  typedef struct packed {
    logic       state;
    logic       rise;
    logic       fall;
    logic [7:0] cnt;
  } exp_t;

  bit   i_Clk = 1'b0;
  logic i_Reset_n;

  switch_debounce_if sw_if ();

  switch_debounce #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .sw        (sw_if.slave)
  );

  always #5 i_Clk = ~i_Clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic raw_hist[$];
  logic sync_hist[$];
  logic m_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one expected result per rising edge.
  always @(posedge i_Clk) begin
    exp_t e;
    logic cur;
    int   run;
    e = '0;
    if (!i_Reset_n) begin
      raw_hist.delete();
      sync_hist.delete();
      m_state = 1'b0;
    end else begin
      // The filter sees the pin level sampled two edges earlier.
      cur = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
      raw_hist.push_back(sw_if.i_Switch);
      sync_hist.push_back(cur);
      run = 0;
      for (int i = sync_hist.size() - 1; i >= 0 && sync_hist[i] != m_state; i--) run++;
      if (run >= LIMIT) begin
        m_state = cur;
        e.rise  = cur;
        e.fall  = ~cur;
      end else begin
        e.cnt = 8'(run);
      end
      while (raw_hist.size() > 2 * LIMIT) raw_hist.pop_front();
      while (sync_hist.size() > 2 * LIMIT) sync_hist.pop_front();
    end
    e.state = m_state;
    exp_q.push_back(e);
  end

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge i_Clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state", 32'(sw_if.o_Switch_state), 32'(e.state));
      check("rise",  32'(sw_if.o_Rise),         32'(e.rise));
      check("fall",  32'(sw_if.o_Fall),         32'(e.fall));
      check("cnt",   32'(dut.cnt),              32'(e.cnt));
    end
  end

  // Hold the current drive for n rising edges; returns just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge i_Clk);
    #1;
  endtask

  // Count rising edges until the debounced level reaches 'level'.
  task automatic expect_latency(input string name, input logic level, input int edges);
    int count;
    count = 0;
    while (sw_if.o_Switch_state !== level && count < 3 * LIMIT) begin
      @(negedge i_Clk);
      count++;
    end
    check(name, 32'(count), 32'(edges));
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with the switch already high.
    i_Reset_n       = 1'b0;
    sw_if.i_Switch  = 1'b1;
    step(5);
    check("reset_state", 32'(sw_if.o_Switch_state), 32'd0);
    check("reset_cnt",   32'(dut.cnt),              32'd0);

    // Switch low after reset, then a clean press.
    sw_if.i_Switch = 1'b0;
    i_Reset_n      = 1'b1;
    step(4);
    sw_if.i_Switch = 1'b1;
    expect_latency("press_latency", 1'b1, LIMIT + 2);
    step(3);

    // Clean release.
    sw_if.i_Switch = 1'b0;
    expect_latency("release_latency", 1'b0, LIMIT + 2);
    step(3);

    // Bounce: 7 high, 1 low, 7 high, then low; never accepted.
    sw_if.i_Switch = 1'b1; step(LIMIT - 1);
    sw_if.i_Switch = 1'b0; step(1);
    sw_if.i_Switch = 1'b1; step(LIMIT - 1);
    sw_if.i_Switch = 1'b0; step(LIMIT + 4);
    check("bounce_state", 32'(sw_if.o_Switch_state), 32'd0);

    // Reset in the middle of a count, switch still high afterwards.
    sw_if.i_Switch = 1'b1; step(5);
    i_Reset_n = 1'b0;      step(2);
    check("midreset_state", 32'(sw_if.o_Switch_state), 32'd0);
    i_Reset_n = 1'b1;
    expect_latency("midreset_latency", 1'b1, LIMIT + 2);
    step(3);

    // Short glitch low while the level is held high.
    sw_if.i_Switch = 1'b0; step(3);
    sw_if.i_Switch = 1'b1; step(LIMIT);
    check("glitch_state", 32'(sw_if.o_Switch_state), 32'd1);
    check("glitch_cnt",   32'(dut.cnt),              32'd0);

    // Randomised segments around the acceptance threshold, with rare resets.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        i_Reset_n = 1'b0;
        step($urandom_range(1, 2));
        i_Reset_n = 1'b1;
      end
      sw_if.i_Switch = 1'($urandom_range(0, 1));
      step($urandom_range(1, LIMIT + 4));
    end

    step(LIMIT + 4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
